acp_burst_writer: RTL

//  Write-DMA stage inside the accelerator, directly upstream of the ACP slave port on the PS.

---
 rtl/acp_pkg.sv | 22 ++
 rtl/acp_burst_writer_if.sv | 38 +++
 rtl/acp_burst_calc.sv | 25 ++
 rtl/acp_burst_writer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/acp_pkg.sv
// Shared constants and FSM state type for the ACP burst writer.
package acp_pkg;

    localparam logic [2:0] AXI_SIZE_64B   = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_PROT_NONE  = 3'b000;
    localparam logic [7:0] AXI_STRB_FULL  = 8'hFF;

    localparam logic [3:0] ACP_CACHE_COHERENT = 4'b1111;
    localparam logic [3:0] ACP_CACHE_NONCOH   = 4'b0011;
    localparam logic [4:0] ACP_USER_COHERENT  = 5'b00001;
    localparam logic [4:0] ACP_USER_NONCOH    = 5'b00000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_t;

endpackage

// File: rtl/acp_burst_writer_if.sv
// AXI3 write-channel bundle (AW/W/B) between the burst writer and the ACP port.
interface acp_burst_writer_if;

    logic [31:0] M_AXI_AWADDR;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic [3:0]  M_AXI_AWCACHE;
    logic [4:0]  M_AXI_AWUSER;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [63:0] M_AXI_WDATA;
    logic [7:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
               M_AXI_AWCACHE, M_AXI_AWUSER, M_AXI_AWPROT, M_AXI_AWVALID,
               M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
               M_AXI_BREADY,
        input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
               M_AXI_AWCACHE, M_AXI_AWUSER, M_AXI_AWPROT, M_AXI_AWVALID,
               M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
               M_AXI_BREADY,
        output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
    );

endinterface

// File: rtl/acp_burst_calc.sv
// Burst sizing: min(remaining beats, BURST_LEN, beats left before the next 4 KB boundary).
module acp_burst_calc #(
    parameter int BURST_LEN = 16,
    parameter int LEN_W     = 16
) (
    input  logic [8:0]       addr_beat,
    input  logic [LEN_W-1:0] remaining,
    output logic [4:0]       burst
);

    localparam int CW = (LEN_W > 10) ? LEN_W : 10;

    logic [9:0]    room;
    logic [CW-1:0] cap;
    logic [CW-1:0] rem_w;

    // addr_beat is addr[11:3], so 512 minus it is the beat distance to the 4 KB page end
    always_comb begin
        room  = 10'd512 - {1'b0, addr_beat};
        cap   = (room < 10'(BURST_LEN)) ? CW'(room) : CW'(BURST_LEN);
        rem_w = CW'(remaining);
        burst = (rem_w < cap) ? 5'(rem_w) : 5'(cap);
    end

endmodule

// File: rtl/acp_burst_writer.sv
// Write-DMA stage: splits one command into 4 KB-safe AXI3 INCR bursts toward the ACP port.
// Build option ACP_COHERENT_EN selects coherent AWCACHE/AWUSER attributes.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high unless done is pulsing
// ADDR  | first cycle registers burst size, then AWVALID held until AWREADY
// DATA  | stream beats pass through to W, beat down-counter drives WLAST
// RESP  | BREADY high, wait for B, advance address/remaining
module acp_burst_writer
    import acp_pkg::*;
#(
    parameter int BURST_LEN = 16,
    parameter int LEN_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [63:0]         s_tdata,
    input  logic                s_tvalid,
    output logic                s_tready,
    acp_burst_writer_if.master  m_axi,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_t           state_q, state_d;
    logic [31:0]      addr_q;
    logic [LEN_W-1:0] rem_q;
    logic [4:0]       burst_q;
    logic [4:0]       beat_q;
    logic [4:0]       burst_calc;
    logic             awvalid_q;
    logic             done_q;
    logic             err_q;
    logic             w_valid;
    logic             b_ready;
    logic             accept;
    logic             w_fire;
    logic             b_fire;
    logic             last_burst;

    acp_burst_calc #(
        .BURST_LEN (BURST_LEN),
        .LEN_W     (LEN_W)
    ) u_calc (
        .addr_beat (addr_q[11:3]),
        .remaining (rem_q),
        .burst     (burst_calc)
    );

    assign accept     = cmd_valid && cmd_ready;
    assign w_fire     = w_valid && m_axi.M_AXI_WREADY;
    assign b_fire     = b_ready && m_axi.M_AXI_BVALID;
    assign last_burst = (rem_q == LEN_W'(burst_q));

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        s_tready  = 1'b0;
        w_valid   = 1'b0;
        b_ready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // no new command in the done cycle, so commands never overlap
                cmd_ready = !done_q;
                if (cmd_valid && !done_q && cmd_len != '0) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (awvalid_q && m_axi.M_AXI_AWREADY) state_d = ST_DATA;
            end
            ST_DATA: begin
                w_valid  = s_tvalid;
                s_tready = m_axi.M_AXI_WREADY;
                if (s_tvalid && m_axi.M_AXI_WREADY && beat_q == 5'd1) state_d = ST_RESP;
            end
            ST_RESP: begin
                b_ready = 1'b1;
                if (m_axi.M_AXI_BVALID) state_d = last_burst ? ST_IDLE : ST_ADDR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            awvalid_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (accept) begin
                addr_q <= cmd_addr & ~32'h7;
                rem_q  <= cmd_len;
                err_q  <= 1'b0;
                done_q <= (cmd_len == '0);
            end
            if (state_q == ST_ADDR) begin
                if (!awvalid_q) begin
                    burst_q   <= burst_calc;
                    beat_q    <= burst_calc;
                    awvalid_q <= 1'b1;
                end else if (m_axi.M_AXI_AWREADY) begin
                    awvalid_q <= 1'b0;
                end
            end
            if (w_fire) beat_q <= beat_q - 5'd1;
            if (b_fire) begin
                err_q  <= err_q | (m_axi.M_AXI_BRESP != AXI_RESP_OKAY);
                addr_q <= addr_q + 32'({burst_q, 3'b000});
                rem_q  <= rem_q - LEN_W'(burst_q);
                done_q <= last_burst;
            end
        end
    end

    assign m_axi.M_AXI_AWADDR  = addr_q;
    assign m_axi.M_AXI_AWLEN   = 8'(burst_q) - 8'd1;
    assign m_axi.M_AXI_AWSIZE  = AXI_SIZE_64B;
    assign m_axi.M_AXI_AWBURST = AXI_BURST_INCR;
    assign m_axi.M_AXI_AWPROT  = AXI_PROT_NONE;
    assign m_axi.M_AXI_AWVALID = awvalid_q;
`ifdef ACP_COHERENT_EN
    assign m_axi.M_AXI_AWCACHE = ACP_CACHE_COHERENT;
    assign m_axi.M_AXI_AWUSER  = ACP_USER_COHERENT;
`else
    assign m_axi.M_AXI_AWCACHE = ACP_CACHE_NONCOH;
    assign m_axi.M_AXI_AWUSER  = ACP_USER_NONCOH;
`endif
    assign m_axi.M_AXI_WDATA   = s_tdata;
    assign m_axi.M_AXI_WSTRB   = AXI_STRB_FULL;
    assign m_axi.M_AXI_WLAST   = (beat_q == 5'd1);
    assign m_axi.M_AXI_WVALID  = w_valid;
    assign m_axi.M_AXI_BREADY  = b_ready;

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign err  = err_q;

endmodule
